// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the instruction fetch stage and its instruction buffer.
package instruction_fetch_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned INST_WIDTH     = 32;
    localparam int unsigned RESET_PC_DEF   = 0;

    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0;

    // Occupancy counter width: must hold the value DEPTH itself.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Synchronous FIFO of {inst, pc} entries with combinational head read.
module inst_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned PC_WIDTH = 5,
    localparam int unsigned CW      = cnt_width(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [INST_WIDTH-1:0] i_push_inst,
    input  logic [PC_WIDTH-1:0]   i_push_pc,
    input  logic                  i_pop,
    output logic [CW-1:0]         o_count,
    output logic [INST_WIDTH-1:0] o_head_inst,
    output logic [PC_WIDTH-1:0]   o_head_pc
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
    logic [PC_WIDTH-1:0]   r_pc_mem   [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);

    // Flush has priority over push; the caller guarantees push never overflows.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush && !i_rst) begin
            r_inst_mem[r_wptr] <= i_push_inst;
            r_pc_mem[r_wptr]   <= i_push_pc;
        end
    end

    assign o_count     = r_count;
    assign o_head_inst = r_inst_mem[r_rptr];
    assign o_head_pc   = r_pc_mem[r_rptr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, credit-based issue to a sync-read imem, redirect flush,
// and valid/ready delivery of buffered words to the decoder.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned RESET_PC   = RESET_PC_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_fetch_enable,
    output logic                  o_imem_rd_en,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic [INST_WIDTH-1:0] i_imem_rdata,
    output logic                  o_inst_valid,
    input  logic                  i_inst_ready,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_inst_pc,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_base_pc,
    input  logic [4:0]            i_redirect_offset
);

    localparam int unsigned CW = cnt_width(FIFO_DEPTH);
    localparam int unsigned SW = (ADDR_WIDTH > 5) ? ADDR_WIDTH + 1 : 6;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_tag;
    logic                  r_inflight;

    logic [CW-1:0]         w_count;
    logic [INST_WIDTH-1:0] w_head_inst;
    logic [ADDR_WIDTH-1:0] w_head_pc;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_issue;
    logic [CW:0]           w_credit;
    logic [SW-1:0]         w_target_sum;

    assign w_valid = !i_rst && (w_count != '0);
    assign w_pop   = w_valid && i_inst_ready;

    // Slots already committed after this cycle's pop; never negative since pop implies count>0.
    assign w_credit = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    assign w_issue  = !i_rst && i_fetch_enable && !i_redirect_valid
                      && (w_credit < (CW+1)'(FIFO_DEPTH));

    assign w_target_sum = SW'(i_redirect_base_pc) + SW'(i_redirect_offset);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= ADDR_WIDTH'(RESET_PC);
            r_inflight <= 1'b0;
            r_tag      <= '0;
        end else begin
            if (i_redirect_valid) begin
                r_pc <= w_target_sum[ADDR_WIDTH-1:0];
            end else if (w_issue) begin
                r_pc <= r_pc + ADDR_WIDTH'(1);
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag <= r_pc;
            end
        end
    end

    inst_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .PC_WIDTH (ADDR_WIDTH)
    ) u_inst_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (i_redirect_valid),
        .i_push      (r_inflight),
        .i_push_inst (i_imem_rdata),
        .i_push_pc   (r_tag),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head_inst (w_head_inst),
        .o_head_pc   (w_head_pc)
    );

    always_comb begin
        o_imem_rd_en = w_issue;
        o_imem_addr  = r_pc;
        o_inst_valid = w_valid;
        o_inst       = w_valid ? w_head_inst : NOP_INST;
        o_inst_pc    = w_valid ? w_head_pc : '0;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench: vector table for start-up, scoreboard of issued words, corner sequences.
module tb_instruction_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fe = 1'b0;
    logic        rdy = 1'b0;
    logic        rv = 1'b0;
    logic [4:0]  base = '0;
    logic [4:0]  off = '0;
    logic        rd_en;
    logic [4:0]  addr;
    logic [31:0] rdata = '0;
    logic        valid;
    logic [31:0] inst;
    logic [4:0]  ipc;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_fetch_enable     (fe),
        .o_imem_rd_en       (rd_en),
        .o_imem_addr        (addr),
        .i_imem_rdata       (rdata),
        .o_inst_valid       (valid),
        .i_inst_ready       (rdy),
        .o_inst             (inst),
        .o_inst_pc          (ipc),
        .i_redirect_valid   (rv),
        .i_redirect_base_pc (base),
        .i_redirect_offset  (off)
    );

    // Instruction memory: word i holds 32'h100 + i, one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rdata <= 32'h100 + {27'b0, addr};
    end

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  pc;
    } ent_t;

    typedef struct {
        bit          r, f, rd, rv;
        logic [4:0]  b, o;
        bit          e_valid, e_rd;
        logic [4:0]  e_addr, e_pc;
        logic [31:0] e_inst;
    } vec_t;

    ent_t buf_q[$];
    bit   m_infl = 1'b0;
    ent_t m_infl_e;
    logic [4:0] m_pc = '0;
    int   acc_pc[$];
    int   errors = 0;
    int   checks = 0;

    logic        s_valid, s_rd;
    logic [4:0]  s_pc, s_addr;
    logic [31:0] s_inst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check outputs, advance the reference model.
    task automatic step(input bit r_v, input bit f_v, input bit rdy_v, input bit rv_v,
                        input logic [4:0] b_v, input logic [4:0] o_v);
        bit exp_valid, exp_pop, exp_rd;
        @(negedge clk);
        rst = r_v; fe = f_v; rdy = rdy_v; rv = rv_v; base = b_v; off = o_v;
        #1;
        s_valid = valid; s_rd = rd_en; s_pc = ipc; s_addr = addr; s_inst = inst;
        exp_valid = !r_v && (buf_q.size() > 0);
        exp_pop   = exp_valid && rdy_v;
        exp_rd    = !r_v && f_v && !rv_v
                    && ((buf_q.size() + int'(m_infl) - int'(exp_pop)) < DEPTH);
        chk("imem_rd_en", rd_en, exp_rd);
        if (exp_rd) chk("imem_addr", addr, m_pc);
        chk("inst_valid", valid, exp_valid);
        if (exp_valid) begin
            chk("inst", inst, buf_q[0].inst);
            chk("inst_pc", ipc, buf_q[0].pc);
        end else begin
            chk("inst_idle", inst, 32'h0);
            chk("inst_pc_idle", ipc, 5'd0);
        end
        if (r_v) begin
            buf_q.delete(); m_infl = 1'b0; m_pc = 5'd0;
        end else if (rv_v) begin
            buf_q.delete(); m_infl = 1'b0; m_pc = b_v + o_v;
        end else begin
            if (exp_pop) begin
                acc_pc.push_back(int'(buf_q[0].pc));
                void'(buf_q.pop_front());
            end
            if (m_infl) buf_q.push_back(m_infl_e);
            m_infl = exp_rd;
            if (exp_rd) begin
                m_infl_e.inst = 32'h100 + {27'b0, m_pc};
                m_infl_e.pc   = m_pc;
                m_pc = m_pc + 5'd1;
            end
        end
    endtask

    task automatic run_accept(input int n, input int limit);
        int start = acc_pc.size();
        int c = 0;
        while ((acc_pc.size() - start) < n && c < limit) begin
            step(0, 1, 1, 0, 5'd0, 5'd0);
            c++;
        end
        chk("accept_budget", ((acc_pc.size() - start) >= n), 1);
    endtask

    function automatic int cont_bad();
        int bad = 0;
        for (int i = 1; i < acc_pc.size(); i++)
            if (acc_pc[i] != ((acc_pc[i-1] + 1) % 32)) bad++;
        return bad;
    endfunction

    vec_t tbl[9];

    initial begin
        // r f rd rv b o | valid rd addr pc inst
        tbl[0] = '{1,1,1,0,0,0, 0,0,5'd0,5'd0,32'h0};
        tbl[1] = '{0,1,1,0,0,0, 0,1,5'd0,5'd0,32'h0};
        tbl[2] = '{0,1,1,0,0,0, 0,1,5'd1,5'd0,32'h0};
        tbl[3] = '{0,1,1,0,0,0, 1,1,5'd2,5'd0,32'h100};
        tbl[4] = '{0,1,1,0,0,0, 1,1,5'd3,5'd1,32'h101};
        tbl[5] = '{0,0,1,0,0,0, 1,0,5'd4,5'd2,32'h102};
        tbl[6] = '{0,0,1,0,0,0, 1,0,5'd4,5'd3,32'h103};
        tbl[7] = '{0,0,1,0,0,0, 0,0,5'd4,5'd0,32'h0};
        tbl[8] = '{0,1,1,0,0,0, 0,1,5'd4,5'd0,32'h0};

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].rd, tbl[i].rv, tbl[i].b, tbl[i].o);
            chk("tbl_valid", s_valid, tbl[i].e_valid);
            chk("tbl_rd_en", s_rd, tbl[i].e_rd);
            chk("tbl_addr", s_addr, tbl[i].e_addr);
            chk("tbl_pc", s_pc, tbl[i].e_pc);
            chk("tbl_inst", s_inst, tbl[i].e_inst);
        end

        // Wrap: 34 consecutive instructions must cross 31 -> 0 exactly once.
        acc_pc.delete();
        run_accept(34, 200);
        begin
            int wraps = 0;
            for (int i = 1; i < acc_pc.size(); i++)
                if (acc_pc[i-1] == 31 && acc_pc[i] == 0) wraps++;
            chk("wrap_seq", cont_bad(), 0);
            chk("wrap_seen", wraps, 1);
        end

        // Backpressure for 5 cycles, then release; nothing lost or duplicated.
        acc_pc.delete();
        run_accept(2, 20);
        begin
            logic [31:0] held;
            step(0, 1, 0, 0, 5'd0, 5'd0);
            held = s_inst;
            for (int i = 0; i < 4; i++) begin
                step(0, 1, 0, 0, 5'd0, 5'd0);
                chk("bp_stable", s_inst, held);
                chk("bp_valid", s_valid, 1'b1);
            end
            chk("bp_rd_en", s_rd, 1'b0);
        end
        run_accept(4, 20);
        chk("bp_continuity", cont_bad(), 0);

        // Redirect base 3 + offset 4 in steady state (word buffered, word in flight).
        step(0, 1, 1, 0, 5'd0, 5'd0);
        acc_pc.delete();
        step(0, 1, 1, 1, 5'd3, 5'd4);
        step(0, 1, 1, 0, 5'd0, 5'd0);
        chk("redir_valid", s_valid, 1'b0);
        chk("redir_addr", s_addr, 5'd7);
        run_accept(3, 20);
        chk("redir_first_pc", acc_pc[0], 7);
        begin
            int wrong = 0;
            foreach (acc_pc[i]) if (acc_pc[i] >= 4 && acc_pc[i] <= 6) wrong++;
            chk("redir_no_wrong_path", wrong, 0);
        end

        // Redirect wrap with a full buffer and a pop offered in the same cycle.
        step(0, 1, 0, 0, 5'd0, 5'd0);
        step(0, 1, 0, 0, 5'd0, 5'd0);
        acc_pc.delete();
        step(0, 1, 1, 1, 5'd30, 5'd5);
        step(0, 1, 1, 0, 5'd0, 5'd0);
        chk("redir_wrap_valid", s_valid, 1'b0);
        chk("redir_wrap_addr", s_addr, 5'd3);
        run_accept(2, 20);
        chk("redir_wrap_first_pc", acc_pc[0], 3);

        // Mid-run reset with a read in flight.
        run_accept(2, 20);
        acc_pc.delete();
        step(1, 1, 1, 0, 5'd0, 5'd0);
        chk("rst_valid", s_valid, 1'b0);
        chk("rst_rd_en", s_rd, 1'b0);
        run_accept(3, 20);
        chk("rst_first_pc", acc_pc[0], 0);
        chk("rst_continuity", cont_bad(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
